// File: rtl/ov7670_stream_emulator.sv
// OV7670 sensor stand-in: drives VSYNC/HREF/D with an RGB444 test pattern,
// two bytes per pixel (xR then GB), so the capture path runs without a camera.
module ov7670_stream_emulator #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BACK    = 17,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam int unsigned LINE_LEN   = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned HREF_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BAR_W      = H_ACTIVE / 8;
  localparam int unsigned BC_W       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned LC_MAX_A   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned LC_MAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned LC_MAX     = (LC_MAX_A > LC_MAX_B) ? LC_MAX_A : LC_MAX_B;
  localparam int unsigned LC_W       = (LC_MAX > 1) ? $clog2(LC_MAX) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_BACK   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_FRONT  = 3'd4;

  logic [2:0]      state_q, state_n;
  logic [BC_W-1:0] bc_q, bc_n;
  logic [LC_W-1:0] lc_q, lc_n;
  logic [LC_W-1:0] lc_last;
  logic [1:0]      mode_q, mode_n;
  logic [11:0]     rgb_q, rgb_n;
  logic [7:0]      fcnt_n;
  logic            start_n;
  logic            line_end;
  logic            start_frame;
  logic [2:0]      follow_state;

  logic            vsync_n;
  logic            href_n;
  logic [7:0]      d_n;
  logic            busy_n;
  logic [11:0]     pix;

  // Register the frame position, latched frame settings and all bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bc_q        <= '0;
      lc_q        <= '0;
      mode_q      <= 2'd0;
      rgb_q       <= 12'd0;
      frame_cnt   <= 8'd0;
      frame_start <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'd0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      bc_q        <= bc_n;
      lc_q        <= lc_n;
      mode_q      <= mode_n;
      rgb_q       <= rgb_n;
      frame_cnt   <= fcnt_n;
      frame_start <= start_n;
      vsync       <= vsync_n;
      href        <= href_n;
      d           <= d_n;
      busy        <= busy_n;
    end
  end

  // Next frame position: walk bytes within a line, lines within a state,
  // and (re)start a frame only from IDLE or at the very end of FRONT.
  always_comb begin
    state_n      = state_q;
    bc_n         = bc_q;
    lc_n         = lc_q;
    mode_n       = mode_q;
    rgb_n        = rgb_q;
    fcnt_n       = frame_cnt;
    start_n      = 1'b0;
    start_frame  = 1'b0;
    lc_last      = '0;
    follow_state = S_IDLE;
    line_end     = (bc_q == BC_W'(LINE_LEN - 1));

    case (state_q)
      S_SYNC: begin
        lc_last      = LC_W'(V_SYNC - 1);
        follow_state = S_BACK;
      end
      S_BACK: begin
        lc_last      = LC_W'(V_BACK - 1);
        follow_state = S_ACTIVE;
      end
      S_ACTIVE: begin
        lc_last      = LC_W'(V_ACTIVE - 1);
        follow_state = S_FRONT;
      end
      S_FRONT: begin
        lc_last      = LC_W'(V_FRONT - 1);
        follow_state = S_IDLE;
      end
      default: begin
        lc_last      = '0;
        follow_state = S_IDLE;
      end
    endcase

    if (state_q == S_IDLE) begin
      start_frame = enable;
    end else if (line_end) begin
      bc_n = '0;
      if (lc_q == lc_last) begin
        lc_n    = '0;
        state_n = follow_state;
        if (state_q == S_FRONT) begin
          start_frame = enable;
        end
      end else begin
        lc_n = lc_q + LC_W'(1);
      end
    end else begin
      bc_n = bc_q + BC_W'(1);
    end

    if (start_frame) begin
      state_n = S_SYNC;
      bc_n    = '0;
      lc_n    = '0;
      mode_n  = mode;
      rgb_n   = solid_rgb;
      fcnt_n  = frame_cnt + 8'd1;
      start_n = 1'b1;
    end
  end

  // Pattern colour for the pixel at the next frame position.
  always_comb begin
    logic [31:0] xe;
    logic [31:0] ye;
    logic        chk;
    xe  = 32'(bc_n >> 1);
    ye  = 32'(lc_n);
    chk = 1'((xe ^ ye) >> CHK_SHIFT);
    pix = 12'h000;
    case (mode_n)
      2'd0: begin
        if      (xe < 32'(BAR_W))     pix = 12'hFFF;
        else if (xe < 32'(2 * BAR_W)) pix = 12'hFF0;
        else if (xe < 32'(3 * BAR_W)) pix = 12'h0FF;
        else if (xe < 32'(4 * BAR_W)) pix = 12'h0F0;
        else if (xe < 32'(5 * BAR_W)) pix = 12'hF0F;
        else if (xe < 32'(6 * BAR_W)) pix = 12'hF00;
        else if (xe < 32'(7 * BAR_W)) pix = 12'h00F;
        else                          pix = 12'h000;
      end
      2'd1:    pix = {4'(xe >> 4), 4'(ye >> 4), fcnt_n[3:0]};
      2'd2:    pix = chk ? 12'hFFF : 12'h000;
      default: pix = rgb_n;
    endcase
  end

  // Bus outputs for the next position; d is forced to zero outside href.
  always_comb begin
    vsync_n = (state_n == S_SYNC);
    href_n  = (state_n == S_ACTIVE) && (bc_n < BC_W'(HREF_BYTES));
    busy_n  = (state_n != S_IDLE);
    d_n     = 8'd0;
    if (href_n) begin
      d_n = bc_n[0] ? pix[7:0] : {4'h0, pix[11:8]};
    end
  end

endmodule
